wb_stage: RTL and testbench

- Memory/writeback pipeline register plus writeback stage; sits directly downstream of the memory stage.
- Captures the memory stage's load data, ALU result, PC+4 and destination control on each clock edge.
- Selects the register-file write value and drives the register-file write port, which also serves as the forwarding source.
- Maintains the retired-instruction counter.

---
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Memory/writeback pipeline register and writeback mux; wb_* outputs appear one cycle after the memory-stage inputs.
// stall holds every field, flush inserts a bubble (flush wins); instret counts each retired instruction once.
module wb_stage #(
  parameter int DATA_W    = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [DATA_W-1:0]    read_data,
  input  logic [DATA_W-1:0]    calculated_result,
  input  logic [DATA_W-1:0]    pc_plus4,
  input  logic [4:0]           rd_addr,
  input  logic                 reg_write,
  input  logic [1:0]           wb_sel,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic [DATA_W-1:0]    wb_data,
  output logic [INSTRET_W-1:0] instret
);

  logic                 valid_q, valid_d;
  logic                 we_q, we_d;
  logic [4:0]           rd_q, rd_d;
  logic [1:0]           sel_q, sel_d;
  logic [DATA_W-1:0]    alu_q, alu_d;
  logic [DATA_W-1:0]    load_q, load_d;
  logic [DATA_W-1:0]    pc4_q, pc4_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    sel_d   = sel_q;
    alu_d   = alu_q;
    load_d  = load_q;
    pc4_d   = pc4_q;
    if (flush) begin
      // Data fields are left as they were; only the qualifiers are cleared.
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall) begin
      valid_d = mem_valid;
      we_d    = reg_write & mem_valid;
      rd_d    = rd_addr;
      sel_d   = wb_sel;
      alu_d   = calculated_result;
      load_d  = read_data;
      pc4_d   = pc_plus4;
    end
  end

  // The instruction in WB leaves unless held; a flush only drops the incoming one.
  assign retire    = valid_q & (~stall | flush);
  assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      sel_q     <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      pc4_q     <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      sel_q     <= sel_d;
      alu_q     <= alu_d;
      load_q    <= load_d;
      pc4_q     <= pc4_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    wb_data = '0;
    case (sel_q)
      2'b00:   wb_data = alu_q;
      2'b01:   wb_data = load_q;
      2'b10:   wb_data = pc4_q;
      default: wb_data = '0;
    endcase
  end

  // Held instructions keep writing so the forwarding path stays valid.
  assign wb_we    = valid_q & we_q & (rd_q != 5'd0);
  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: full-width and 4-bit-counter instances share stimulus and are checked against an instruction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, mem_valid = 1'b0, reg_write = 1'b0;
  logic [31:0] read_data = '0, calculated_result = '0, pc_plus4 = '0;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  wb_sel = '0;

  logic        wb_valid, wb_we, s_valid, s_we;
  logic [4:0]  wb_rd, s_rd;
  logic [31:0] wb_data, s_data;
  logic [63:0] instret;
  logic [3:0]  s_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .read_data(read_data), .calculated_result(calculated_result), .pc_plus4(pc_plus4),
    .rd_addr(rd_addr), .reg_write(reg_write), .wb_sel(wb_sel),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .instret(instret)
  );

  wb_stage #(.DATA_W(32), .INSTRET_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .read_data(read_data), .calculated_result(calculated_result), .pc_plus4(pc_plus4),
    .rd_addr(rd_addr), .reg_write(reg_write), .wb_sel(wb_sel),
    .wb_valid(s_valid), .wb_rd(s_rd), .wb_we(s_we), .wb_data(s_data), .instret(s_instret)
  );

  // Model: the instruction record sitting in WB plus a retirement tally.
  typedef struct {
    bit          v;
    bit          we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu, ld, pc4;
  } instr_t;

  instr_t      m_wb;
  logic [63:0] m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wb  = '{v: 0, we: 0, rd: 0, sel: 0, alu: 0, ld: 0, pc4: 0};
      m_cnt = 0;
    end else begin
      if (m_wb.v && (!stall || flush)) m_cnt = m_cnt + 1;
      if (flush) begin
        m_wb.v  = 0;
        m_wb.we = 0;
      end else if (!stall) begin
        m_wb = '{v: mem_valid, we: reg_write && mem_valid, rd: rd_addr, sel: wb_sel,
                 alu: calculated_result, ld: read_data, pc4: pc_plus4};
      end
    end
  end

  function automatic logic [31:0] exp_data(instr_t i);
    case (i.sel)
      2'b00:   return i.alu;
      2'b01:   return i.ld;
      2'b10:   return i.pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_we(instr_t i);
    return i.v && i.we && (i.rd != 5'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("valid", {63'd0, wb_valid}, {63'd0, m_wb.v});
      chk("rd", {59'd0, wb_rd}, {59'd0, m_wb.rd});
      chk("we", {63'd0, wb_we}, {63'd0, exp_we(m_wb)});
      chk("data", {32'd0, wb_data}, {32'd0, exp_data(m_wb)});
      chk("instret", instret, m_cnt);
      chk("instret4", {60'd0, s_instret}, {60'd0, m_cnt[3:0]});
      chk("small_match", {s_valid, s_we, s_rd, s_data}, {wb_valid, wb_we, wb_rd, wb_data});
    end
  end

  task automatic drive(input bit v, input logic [4:0] rd, input bit rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                       input bit st, input bit fl);
    mem_valid = v; rd_addr = rd; reg_write = rw; wb_sel = sel;
    calculated_result = alu; read_data = ld; pc_plus4 = pc4;
    stall = st; flush = fl;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input bit check_lit);
    #2 rst = 1'b0;
    #1;
    if (check_lit) begin
      chk("arst_valid", {63'd0, wb_valid}, 64'd0);
      chk("arst_we", {63'd0, wb_we}, 64'd0);
      chk("arst_instret", instret, 64'd0);
      chk("arst_instret4", {60'd0, s_instret}, 64'd0);
      chk("arst_data", {32'd0, wb_data}, 64'd0);
    end
    #1 rst = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_we", {63'd0, wb_we}, 64'd0);
    chk("rst_data", {32'd0, wb_data}, 64'd0);
    chk("rst_instret", instret, 64'd0);

    step();
    rst = 1'b1;
    drive(1, 5'd5, 1, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    step();
    chk("cap_valid", {63'd0, wb_valid}, 64'd1);
    chk("cap_we", {63'd0, wb_we}, 64'd1);
    chk("cap_rd", {59'd0, wb_rd}, 64'd5);
    chk("cap_data", {32'd0, wb_data}, 64'h1234);
    chk("cap_instret", instret, 64'd0);

    drive(1, 5'd6, 1, 2'b01, 32'h1111, 32'hFFFF_FF80, 32'h2222, 0, 0);
    step();
    chk("sel_load", {32'd0, wb_data}, 64'hFFFF_FF80);
    chk("instret_1", instret, 64'd1);
    drive(1, 5'd1, 1, 2'b10, 32'h1111, 32'h3333, 32'h0000_0104, 0, 0);
    step();
    chk("sel_pc4", {32'd0, wb_data}, 64'h104);
    drive(1, 5'd8, 1, 2'b11, 32'h5555, 32'h6666, 32'h7777, 0, 0);
    step();
    chk("sel_rsvd", {32'd0, wb_data}, 64'd0);
    chk("instret_3", instret, 64'd3);

    drive(1, 5'd0, 1, 2'b00, 32'h9, 32'h0, 32'h0, 0, 0);
    step();
    chk("x0_valid", {63'd0, wb_valid}, 64'd1);
    chk("x0_we", {63'd0, wb_we}, 64'd0);

    drive(1, 5'd7, 1, 2'b00, 32'h0000_AAAA, 32'h0, 32'h0, 0, 0);
    step();
    chk("x0_retired", instret, 64'd5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 10), 1, 2'(i), $urandom, $urandom, $urandom, 1, 0);
      step();
      chk("stall_rd", {59'd0, wb_rd}, 64'd7);
      chk("stall_data", {32'd0, wb_data}, 64'hAAAA);
      chk("stall_we", {63'd0, wb_we}, 64'd1);
      chk("stall_instret", instret, 64'd5);
    end
    drive(0, 5'd3, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0);
    step();
    chk("unstall_instret", instret, 64'd6);
    chk("bubble_valid", {63'd0, wb_valid}, 64'd0);
    step();
    chk("bubble_instret", instret, 64'd6);

    drive(1, 5'd9, 1, 2'b00, 32'h99, 32'h0, 32'h0, 0, 0);
    step();
    drive(1, 5'd10, 1, 2'b00, 32'h77, 32'h0, 32'h0, 1, 1);
    step();
    chk("flush_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_we", {63'd0, wb_we}, 64'd0);
    chk("flush_instret", instret, 64'd7);
    drive(0, 5'd0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0);
    step();
    chk("flush_once", instret, 64'd7);

    for (int i = 0; i < 10; i++) begin
      drive(1, 5'($urandom_range(1, 31)), 1, 2'b00, $urandom, $urandom, $urandom, 0, 0);
      step();
      if (i == 8) chk("wrap_15", {60'd0, s_instret}, 64'd15);
      if (i == 9) begin
        chk("wrap_0", {60'd0, s_instret}, 64'd0);
        chk("wide_16", instret, 64'd16);
      end
    end
    chk("pre_arst_valid", {63'd0, wb_valid}, 64'd1);
    async_reset_pulse(1);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if (i % 97 == 50) async_reset_pulse(0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
